// File: rtl/spike_pkg.sv
// spike_pkg: shared types and defaults for the spike sender and its consumers.
//   spike_tx_state_t : transmit FSM state encoding
//   SPIKE_DATA_BITS  : default word width, shared with the neuron bench
package spike_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    REQ,
    ACKLOW
  } spike_tx_state_t;

  localparam int unsigned SPIKE_DATA_BITS = 4;

endpackage

// File: rtl/spike_sender_if.sv
// spike_sender_if: valid/ready word-input channel into the spike sender.
//   in_valid : word offered on in_data
//   in_ready : sender can accept a word (FIFO not full)
//   in_data  : DATA_BITS-wide word to send
// Modports: master = word producer, slave = spike_sender.
interface spike_sender_if #(
  parameter int unsigned DATA_BITS = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_BITS-1:0] in_data;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/spike_sender_ack_sync.sv
// ack_sync: SYNC_STAGES-deep flop chain bringing the asynchronous ack into clk.
//   clk, rst_n : clock, async active-low reset (chain resets to 0)
//   async_i    : asynchronous input
//   sync_o     : synchronized output
module ack_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spike_sender.sv
// spike_sender: buffers words from the synchronous domain and sends each one
// LSB-first over a bundled-data 4-phase channel (data_out/req_out/ack_in),
// one bit per full handshake.
//   clk, rst_n : clock (rising), async active-low reset
//   in_if      : valid/ready word input (spike_sender_if.slave)
//   data_out   : bundled data bit
//   req_out    : 4-phase request
//   ack_in     : 4-phase acknowledge (asynchronous)
//   busy       : FIFO non-empty or handshake in progress
//   word_done  : 1-cycle pulse when a word's last handshake completes
//   err        : sticky ack-timeout flag
// Optional feature macro SPIKE_TIMEOUT_EN: abort a handshake (drop the word,
// set err) when no ack edge arrives within TIMEOUT_CYC cycles.
module spike_sender
  import spike_pkg::*;
#(
  parameter int unsigned DATA_BITS   = SPIKE_DATA_BITS,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  spike_sender_if.slave  in_if,
  output logic           data_out,
  output logic           req_out,
  input  logic           ack_in,
  output logic           busy,
  output logic           word_done,
  output logic           err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int unsigned CW = $clog2(SETUP_CYC + 1);

  // ---------------- FIFO ----------------
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_q, rd_ptr_q;
  logic                 empty, full, push, pop;
  logic [DATA_BITS-1:0] head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = in_if.in_valid && in_if.in_ready;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign in_if.in_ready = !full;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_if.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // ---------------- ack synchronizer ----------------
  logic ack_s;

  ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (ack_in),
    .sync_o  (ack_s)
  );

  // ---------------- transmit FSM ----------------
  spike_tx_state_t      state_q;
  logic [DATA_BITS-1:0] shift_q, shift_next;
  logic [BW-1:0]        bit_q;
  logic [CW-1:0]        setup_q;
  logic                 data_out_q, req_out_q, word_done_q;
  logic                 last_bit, tmo_hit;

  assign shift_next = shift_q >> 1;
  assign last_bit   = (bit_q == BW'(DATA_BITS - 1));

`ifdef SPIKE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q;
  logic          err_q;

  assign tmo_hit = ((state_q == REQ) || (state_q == ACKLOW)) &&
                   (tmo_q == TW'(TIMEOUT_CYC));
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (tmo_hit) err_q <= 1'b1;
      // Restart on every entry into a wait state; count while waiting.
      if ((state_q == SETUP) || ((state_q == REQ) && ack_s))
        tmo_q <= '0;
      else if ((state_q == REQ) || (state_q == ACKLOW))
        tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  // Head is popped only when its word finishes (or is aborted), so it stays
  // resident in the FIFO for the whole transfer.
  assign pop = tmo_hit || ((state_q == ACKLOW) && !ack_s && last_bit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_q       <= '0;
      setup_q     <= '0;
      data_out_q  <= 1'b0;
      req_out_q   <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      word_done_q <= 1'b0;
      if (tmo_hit) begin
        req_out_q  <= 1'b0;
        data_out_q <= 1'b0;
        state_q    <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (!empty) begin
              shift_q    <= head;
              bit_q      <= '0;
              setup_q    <= '0;
              // Drive the bit on SETUP entry so it has SETUP_CYC full cycles
              // before req_out rises.
              data_out_q <= head[0];
              state_q    <= SETUP;
            end
          end
          SETUP: begin
            data_out_q <= shift_q[0];
            if (setup_q == CW'(SETUP_CYC - 1)) begin
              req_out_q <= 1'b1;
              state_q   <= REQ;
            end else begin
              setup_q <= setup_q + 1'b1;
            end
          end
          REQ: begin
            if (ack_s) begin
              req_out_q <= 1'b0;
              state_q   <= ACKLOW;
            end
          end
          ACKLOW: begin
            // A stale high ack simply keeps us here; req_out stays low.
            if (!ack_s) begin
              if (last_bit) begin
                word_done_q <= 1'b1;
                data_out_q  <= 1'b0;
                state_q     <= IDLE;
              end else begin
                shift_q    <= shift_next;
                data_out_q <= shift_next[0];
                bit_q      <= bit_q + 1'b1;
                setup_q    <= '0;
                state_q    <= SETUP;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data_out  = data_out_q;
  assign req_out   = req_out_q;
  assign word_done = word_done_q;
  assign busy      = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_spike_sender.sv
module tb_spike_sender;
  import spike_pkg::*;

  localparam int unsigned DB = SPIKE_DATA_BITS;
  localparam int unsigned FD = 4;
  localparam int unsigned SC = 1;
  localparam int unsigned SS = 2;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic data_out, req_out, ack_in, busy, word_done, err;

  spike_sender_if #(.DATA_BITS(DB)) in_if ();

  spike_sender #(
    .DATA_BITS   (DB),
    .FIFO_DEPTH  (FD),
    .SETUP_CYC   (SC),
    .SYNC_STAGES (SS),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_if     (in_if),
    .data_out  (data_out),
    .req_out   (req_out),
    .ack_in    (ack_in),
    .busy      (busy),
    .word_done (word_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] got_q[$];
  bit stall = 1'b0;
  int ack_dly = 3;
  int req_rises = 0;
  int dones = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Neuron model: captures data_out at each req rise, acks after ack_dly
  // cycles (held off while stall=1), drops ack 2 cycles after req falls.
  initial begin : neuron
    int st;
    int dly;
    int nb;
    logic [DB-1:0] w;
    st = 0; dly = 0; nb = 0; w = '0;
    ack_in = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        st = 0; nb = 0; w = '0; ack_in = 1'b0;
      end else begin
        case (st)
          0: if (req_out) begin
               w[nb] = data_out;
               nb++;
               req_rises++;
               dly = 0;
               st = 1;
               if (nb == DB) begin
                 got_q.push_back(w);
                 nb = 0;
                 w = '0;
               end
             end
          1: if (!req_out) begin
               st = 0; nb = 0; w = '0;
             end else if (!stall) begin
               dly++;
               if (dly >= ack_dly) begin
                 ack_in = 1'b1;
                 st = 2;
               end
             end
          2: if (!req_out) begin
               dly = 0;
               st = 3;
             end
          default: begin
               dly++;
               if (dly >= 2) begin
                 ack_in = 1'b0;
                 st = 0;
               end
             end
        endcase
      end
    end
  end

  // Scoreboard monitor: each word_done pops one expected and one received word.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && word_done) begin
        dones++;
        chk("sb_nonempty", 32'(exp_q.size() != 0 && got_q.size() != 0), 1);
        if (exp_q.size() != 0 && got_q.size() != 0)
          chk("word", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
      end
    end
  end

  // Bundled-data protocol checker.
  initial begin : proto
    logic prev_req;
    logic prev_data;
    int stable;
    prev_req = 1'b0; prev_data = 1'b0; stable = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 1'b0; prev_data = 1'b0; stable = 0;
      end else begin
        if (data_out == prev_data) stable++;
        else stable = 0;
        if (req_out && !prev_req) begin
          chk("setup_time", 32'(stable >= int'(SC)), 1);
          chk("req_rise_ack_low", 32'(ack_in), 0);
        end
        if (req_out && prev_req) chk("data_stable", 32'(data_out), 32'(prev_data));
        prev_req  = req_out;
        prev_data = data_out;
      end
    end
  end

  task automatic push_word(input logic [DB-1:0] w, input bit expect_it);
    int n;
    n = 0;
    in_if.in_valid = 1'b1;
    in_if.in_data  = w;
    while (!in_if.in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("push_timeout", 32'(in_if.in_ready), 1);
    if (expect_it) exp_q.push_back(w);
    @(posedge clk);
    #1 in_if.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_busy", 32'(busy), 0);
    chk("drain_pending", 32'(exp_q.size()), 0);
  endtask

  task automatic wait_req(input int maxc);
    int n;
    n = 0;
    while (!req_out && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 32'(req_out), 1);
  endtask

  initial begin : main
    int n;
    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_req_out", 32'(req_out), 0);
    chk("rst_in_ready", 32'(in_if.in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_word_done", 32'(word_done), 0);
    chk("rst_err", 32'(err), 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // 1: single word 1011 -> bits 1,1,0,1; 4 handshakes, one word_done
    push_word(4'b1011, 1'b1);
    wait_idle(400);
    chk("t1_req_pulses", 32'(req_rises), 4);
    chk("t1_word_done", 32'(dones), 1);

    // 2: five words with ack stalled; four fit, fifth waits for a pop
    stall = 1'b1;
    push_word(4'h6, 1'b1);
    push_word(4'h9, 1'b1);
    push_word(4'h0, 1'b1);
    push_word(4'hF, 1'b1);
    chk("t2_full_in_ready", 32'(in_if.in_ready), 0);
    chk("t2_busy", 32'(busy), 1);
    stall = 1'b0;
    push_word(4'h3, 1'b1);
    wait_idle(2000);
    chk("t2_word_done", 32'(dones), 6);

    // 4: reset while req_out=1 with words still queued
    stall = 1'b1;
    push_word(4'hB, 1'b0);
    push_word(4'h7, 1'b0);
    wait_req(50);
    chk("t4_data_before_rst", 32'(data_out), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_req_async", 32'(req_out), 0);
    chk("t4_data_async", 32'(data_out), 0);
    chk("t4_fifo_empty", 32'(busy), 0);
    chk("t4_in_ready", 32'(in_if.in_ready), 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    stall = 1'b0;
    @(negedge clk);
    push_word(4'h5, 1'b1);
    wait_idle(400);
    chk("t4_word_done", 32'(dones), 7);

`ifdef SPIKE_TIMEOUT_EN
    // 5: ack stuck low -> err 17 cycles after REQ entry, word dropped
    stall = 1'b1;
    push_word(4'hD, 1'b0);
    wait_req(50);
    n = 0;
    while (!err && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_err_latency", 32'(n), 17);
    chk("t5_err", 32'(err), 1);
    chk("t5_req_low", 32'(req_out), 0);
    chk("t5_data_low", 32'(data_out), 0);
    stall = 1'b0;
    push_word(4'h4, 1'b1);
    wait_idle(400);
    chk("t5_err_sticky", 32'(err), 1);
    chk("t5_word_done", 32'(dones), 8);
`else
    // 6: ack stuck low for 1000 cycles -> request held, no error
    stall = 1'b1;
    push_word(4'h2, 1'b1);
    repeat (1000) @(negedge clk);
    chk("t6_req_held", 32'(req_out), 1);
    chk("t6_err", 32'(err), 0);
    chk("t6_busy", 32'(busy), 1);
    stall = 1'b0;
    wait_idle(400);
    chk("t6_word_done", 32'(dones), 8);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
